alu_result_sel_pipe: RTL and testbench

//  Registered, parametrised result selector for the ZMC ALU. Routes result + Z/S/C/OVR flags

---
 rtl/alu_result_sel_pipe.sv | 183 ++++++++++++++++++
 tb/tb_alu_result_sel_pipe.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_result_sel_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : alu_result_sel_pipe
//  Purpose  : Registered result/flag selector for the ZMC ALU. Routes the
//             result and {z,s,c,ovr} flags of one of NUM_UNITS execution
//             units to the ZMC. Single-cycle units complete one clock after
//             issue; multi-cycle units (MC_MASK) are tracked by an IDLE/WAIT
//             FSM that waits for the unit's done strobe or times out.
//  Ports    : clk, rst_n (async, active low)
//             unit_data_in  [NUM_UNITS*DATA_WL] lane i = [i*DATA_WL +: DATA_WL]
//             unit_flags_in [NUM_UNITS*4]       lane i = {z,s,c,ovr}
//             unit_valid_in [NUM_UNITS]         done strobes (MC lanes only)
//             active_vec    [NUM_UNITS]         one-hot unit select
//             issue_in                          new operation this cycle
//             c_out, z/s/c/ovr_flag_out         registered result and flags
//             valid_out                         1-cycle completion pulse
//             busy_out                          high while waiting on MC unit
//             timeout_out                       1-cycle timed-out completion
//             err_out (ALU_SEL_ERR_EN only)     illegal select or timeout
//  Config   : define ALU_SEL_ERR_EN to add err_out.
//  Revision : 1.0  initial release
// ============================================================================
module alu_result_sel_pipe #(
  parameter int                   DATA_WL   = 16,
  parameter int                   NUM_UNITS = 4,
  parameter logic [NUM_UNITS-1:0] MC_MASK   = 4'b1000,
  parameter int                   TIMEOUT   = 32
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_UNITS*DATA_WL-1:0] unit_data_in,
  input  logic [NUM_UNITS*4-1:0]       unit_flags_in,
  input  logic [NUM_UNITS-1:0]         unit_valid_in,
  input  logic [NUM_UNITS-1:0]         active_vec,
  input  logic                         issue_in,
  output logic [DATA_WL-1:0]           c_out,
  output logic                         z_flag_out,
  output logic                         s_flag_out,
  output logic                         c_flag_out,
  output logic                         ovr_flag_out,
  output logic                         valid_out,
  output logic                         busy_out,
  output logic                         timeout_out
`ifdef ALU_SEL_ERR_EN
  ,output logic                        err_out
`endif
);

  localparam int                 CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t               state, next_state;
  logic [NUM_UNITS-1:0] sel_q;
  logic [CNT_W-1:0]     wait_cnt;

  logic [DATA_WL-1:0]   lane_data  [NUM_UNITS];
  logic [3:0]           lane_flags [NUM_UNITS];

  logic [NUM_UNITS-1:0] mux_sel;
  logic [DATA_WL-1:0]   sel_data;
  logic [3:0]           sel_flags;
  logic                 sel_valid;
  logic                 is_onehot;
  logic                 is_mc;
  logic                 complete;
  logic                 load_zero;
  logic                 timed_out;
  logic                 enter_wait;

  generate
    for (genvar g = 0; g < NUM_UNITS; g++) begin : g_lane
      assign lane_data[g]  = unit_data_in[g*DATA_WL +: DATA_WL];
      assign lane_flags[g] = unit_flags_in[g*4 +: 4];
    end
  endgenerate

  // In WAIT only the latched select matters; new issues are ignored.
  assign mux_sel   = (state == ST_WAIT) ? sel_q : active_vec;
  assign is_onehot = (active_vec != '0) &&
                     ((active_vec & (active_vec - NUM_UNITS'(1))) == '0);
  assign is_mc     = |(active_vec & MC_MASK);
  assign sel_valid = |(unit_valid_in & sel_q);

  // mux_sel is one-hot whenever the muxed value is used, so OR-reduction works.
  always_comb begin
    sel_data  = '0;
    sel_flags = '0;
    for (int i = 0; i < NUM_UNITS; i++) begin
      if (mux_sel[i]) begin
        sel_data  = sel_data  | lane_data[i];
        sel_flags = sel_flags | lane_flags[i];
      end
    end
  end

  always_comb begin
    next_state = state;
    complete   = 1'b0;
    load_zero  = 1'b0;
    timed_out  = 1'b0;
    enter_wait = 1'b0;
    case (state)
      ST_IDLE: begin
        if (issue_in) begin
          if (!is_onehot) begin
            complete  = 1'b1;
            load_zero = 1'b1;
          end else if (is_mc) begin
            enter_wait = 1'b1;
            next_state = ST_WAIT;
          end else begin
            complete = 1'b1;
          end
        end
      end
      ST_WAIT: begin
        // A done strobe on the final cycle still wins over the timeout.
        if (sel_valid) begin
          complete   = 1'b1;
          next_state = ST_IDLE;
        end else if (wait_cnt == CNT_LAST) begin
          complete   = 1'b1;
          load_zero  = 1'b1;
          timed_out  = 1'b1;
          next_state = ST_IDLE;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_IDLE;
      sel_q        <= '0;
      wait_cnt     <= '0;
      c_out        <= '0;
      z_flag_out   <= 1'b0;
      s_flag_out   <= 1'b0;
      c_flag_out   <= 1'b0;
      ovr_flag_out <= 1'b0;
      valid_out    <= 1'b0;
      timeout_out  <= 1'b0;
    end else begin
      state       <= next_state;
      valid_out   <= complete;
      timeout_out <= timed_out;
      if (enter_wait) begin
        sel_q    <= active_vec;
        wait_cnt <= '0;
      end else if (state == ST_WAIT && next_state == ST_WAIT) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (complete) begin
        c_out        <= load_zero ? '0   : sel_data;
        z_flag_out   <= load_zero ? 1'b0 : sel_flags[3];
        s_flag_out   <= load_zero ? 1'b0 : sel_flags[2];
        c_flag_out   <= load_zero ? 1'b0 : sel_flags[1];
        ovr_flag_out <= load_zero ? 1'b0 : sel_flags[0];
      end
    end
  end

  assign busy_out = (state == ST_WAIT);

`ifdef ALU_SEL_ERR_EN
  // Every zero-forced completion is either an illegal select or a timeout.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_out <= 1'b0;
    end else begin
      err_out <= complete & load_zero;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_alu_result_sel_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alu_result_sel_pipe
//  Purpose  : Directed self-checking bench for alu_result_sel_pipe
//             (DATA_WL=16, NUM_UNITS=4, MC_MASK=4'b1000, TIMEOUT=32).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alu_result_sel_pipe;

  localparam int TMO = 32;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] unit_data_in;
  logic [15:0] unit_flags_in;
  logic [3:0]  unit_valid_in;
  logic [3:0]  active_vec;
  logic        issue_in;
  logic [15:0] c_out;
  logic        z_flag_out, s_flag_out, c_flag_out, ovr_flag_out;
  logic        valid_out, busy_out, timeout_out;
  logic [3:0]  flags;
`ifdef ALU_SEL_ERR_EN
  logic        err_out;
`endif

  int checks   = 0;
  int failures = 0;

  alu_result_sel_pipe #(
    .DATA_WL  (16),
    .NUM_UNITS(4),
    .MC_MASK  (4'b1000),
    .TIMEOUT  (TMO)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .unit_data_in (unit_data_in),
    .unit_flags_in(unit_flags_in),
    .unit_valid_in(unit_valid_in),
    .active_vec   (active_vec),
    .issue_in     (issue_in),
    .c_out        (c_out),
    .z_flag_out   (z_flag_out),
    .s_flag_out   (s_flag_out),
    .c_flag_out   (c_flag_out),
    .ovr_flag_out (ovr_flag_out),
    .valid_out    (valid_out),
    .busy_out     (busy_out),
    .timeout_out  (timeout_out)
`ifdef ALU_SEL_ERR_EN
    ,.err_out     (err_out)
`endif
  );

  always #5 clk = ~clk;

  assign flags = {z_flag_out, s_flag_out, c_flag_out, ovr_flag_out};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n         = 1'b0;
    unit_data_in  = '0;
    unit_flags_in = '0;
    unit_valid_in = '0;
    active_vec    = '0;
    issue_in      = 1'b0;
    tick();
    tick();
    chk("rst_c_out", c_out, 0);
    chk("rst_flags", flags, 0);
    chk("rst_valid", valid_out, 0);
    chk("rst_busy", busy_out, 0);
    chk("rst_timeout", timeout_out, 0);
    rst_n = 1'b1;

    // Lane data: 0=1234/c, 1=5555/z, 2=AAAA/s+ovr, 3=BEEF/ovr
    unit_data_in  = {16'hBEEF, 16'hAAAA, 16'h5555, 16'h1234};
    unit_flags_in = {4'b0001, 4'b0101, 4'b1000, 4'b0010};

    // Single-cycle issue, latency 1
    active_vec = 4'b0001; issue_in = 1'b1;
    tick();
    chk("sc_c_out", c_out, 16'h1234);
    chk("sc_flags", flags, 4'b0010);
    chk("sc_valid", valid_out, 1);
    chk("sc_busy", busy_out, 0);
    issue_in = 1'b0;
    tick();
    chk("sc_valid_pulse", valid_out, 0);
    chk("sc_hold", c_out, 16'h1234);

    // Back-to-back single-cycle issues
    active_vec = 4'b0010; issue_in = 1'b1;
    tick();
    chk("b2b1_c_out", c_out, 16'h5555);
    chk("b2b1_flags", flags, 4'b1000);
    chk("b2b1_valid", valid_out, 1);
    active_vec = 4'b0100;
    tick();
    chk("b2b2_c_out", c_out, 16'hAAAA);
    chk("b2b2_flags", flags, 4'b0101);
    chk("b2b2_valid", valid_out, 1);
    issue_in = 1'b0;
    tick();
    chk("b2b_end_valid", valid_out, 0);

    // Multi-cycle: done strobe in the 5th WAIT cycle; issues and foreign strobes ignored
    active_vec = 4'b1000; issue_in = 1'b1;
    tick();
    chk("mc_busy0", busy_out, 1);
    chk("mc_valid0", valid_out, 0);
    active_vec = 4'b0001; unit_valid_in = 4'b0001;
    for (int k = 1; k < 5; k++) begin
      tick();
      chk("mc_busy", busy_out, 1);
      chk("mc_no_valid", valid_out, 0);
      chk("mc_hold", c_out, 16'hAAAA);
    end
    issue_in = 1'b0; unit_valid_in = 4'b1000;
    tick();
    chk("mc_c_out", c_out, 16'hBEEF);
    chk("mc_flags", flags, 4'b0001);
    chk("mc_valid", valid_out, 1);
    chk("mc_busy_clr", busy_out, 0);
    chk("mc_timeout", timeout_out, 0);
    unit_valid_in = 4'b0000;
    tick();
    chk("mc_valid_pulse", valid_out, 0);

    // Timeout: busy for TMO cycles, then forced zero completion
    active_vec = 4'b1000; issue_in = 1'b1;
    tick();
    issue_in = 1'b0;
    chk("to_busy_first", busy_out, 1);
    for (int k = 1; k < TMO; k++) tick();
    chk("to_busy_last", busy_out, 1);
    chk("to_not_yet", valid_out, 0);
    tick();
    chk("to_c_out", c_out, 0);
    chk("to_flags", flags, 0);
    chk("to_valid", valid_out, 1);
    chk("to_timeout", timeout_out, 1);
    chk("to_busy_clr", busy_out, 0);
`ifdef ALU_SEL_ERR_EN
    chk("to_err", err_out, 1);
`endif
    tick();
    chk("to_timeout_pulse", timeout_out, 0);

    // Done strobe on the last WAIT cycle wins over timeout
    unit_data_in[63:48]  = 16'hCAFE;
    unit_flags_in[15:12] = 4'b0100;
    active_vec = 4'b1000; issue_in = 1'b1;
    tick();
    issue_in = 1'b0;
    for (int k = 1; k < TMO; k++) tick();
    unit_valid_in = 4'b1000;
    tick();
    unit_valid_in = 4'b0000;
    chk("tov_c_out", c_out, 16'hCAFE);
    chk("tov_flags", flags, 4'b0100);
    chk("tov_valid", valid_out, 1);
    chk("tov_timeout", timeout_out, 0);

    // Illegal selects: two bits, then none
    active_vec = 4'b0011; issue_in = 1'b1;
    tick();
    chk("ill2_c_out", c_out, 0);
    chk("ill2_flags", flags, 0);
    chk("ill2_valid", valid_out, 1);
    chk("ill2_busy", busy_out, 0);
`ifdef ALU_SEL_ERR_EN
    chk("ill2_err", err_out, 1);
`endif
    active_vec = 4'b0001;
    tick();
    chk("ill_restore", c_out, 16'h1234);
    active_vec = 4'b0000; unit_valid_in = 4'b1000;
    tick();
    unit_valid_in = 4'b0000;
    chk("ill0_c_out", c_out, 0);
    chk("ill0_flags", flags, 0);
    chk("ill0_valid", valid_out, 1);
    chk("ill0_timeout", timeout_out, 0);
    issue_in = 1'b0;
    tick();
    chk("ill0_valid_pulse", valid_out, 0);

    // Reset while in WAIT, then a clean single-cycle op with stale strobe
    active_vec = 4'b0001; issue_in = 1'b1;
    tick();
    active_vec = 4'b1000;
    tick();
    issue_in = 1'b0;
    tick();
    tick();
    chk("rw_busy_pre", busy_out, 1);
    chk("rw_c_out_pre", c_out, 16'h1234);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rw_async_c_out", c_out, 0);
    chk("rw_async_busy", busy_out, 0);
    chk("rw_async_flags", flags, 0);
    tick();
    rst_n = 1'b1;
    unit_valid_in = 4'b1000;
    active_vec = 4'b0001; issue_in = 1'b1;
    tick();
    chk("rw_sc_c_out", c_out, 16'h1234);
    chk("rw_sc_valid", valid_out, 1);
    chk("rw_sc_busy", busy_out, 0);
    issue_in = 1'b0;
    tick();
    chk("rw_stale_valid", valid_out, 0);
    chk("rw_stale_c_out", c_out, 16'h1234);
    chk("rw_stale_timeout", timeout_out, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
